// File: rtl/program_loader_pkg.sv
// Shared types and protocol constants for the UART program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HELLO_REQ,
    ST_HELLO_WAIT,
    ST_HDR,
    ST_DATA,
    ST_ACK_REQ,
    ST_ACK_WAIT,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam logic [7:0] HELLO_BYTE = 8'hAA;
  localparam logic [7:0] NACK_BYTE  = 8'h55;

  // Bytes per big-endian word, shared by the length header and the data words.
  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Collects four MSB-first bytes into a 32-bit word and strobes word_valid
// for one cycle, the cycle after the fourth byte was accepted.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_ready,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_valid;

  // Shift in accepted bytes; the byte counter wraps 3->0 on its own.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_rx_ready) begin
        r_word <= {r_word[23:0], i_rx_data};
        r_cnt  <= r_cnt + 2'd1;
        if (r_cnt == LAST_BYTE) r_valid <= 1'b1;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;

endmodule

// File: rtl/program_loader.sv
// Boot-time UART program loader: sends a hello byte, receives a word count
// and that many big-endian words, writes them to instruction memory and
// acknowledges with a success or nack byte.
module program_loader #(
  parameter int unsigned INST_SIZE  = 10,
  parameter logic [7:0]  HELLO_BYTE = loader_pkg::HELLO_BYTE,
  parameter logic [7:0]  NACK_BYTE  = loader_pkg::NACK_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 imem_we,
  output logic [INST_SIZE-1:0] imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 load_done,
  output logic                 load_err
);

  import loader_pkg::*;

  localparam logic [31:0] MAX_WORDS = 32'(1) << INST_SIZE;

  loader_state_t      r_state;
  logic               r_first;
  logic               r_nack;
  logic [INST_SIZE:0] r_k;
  logic [INST_SIZE:0] r_n;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic               r_done;
  logic               r_err;

  logic               w_asm_en;
  logic               w_asm_rx;
  logic               w_word_valid;
  logic [31:0]        w_word;

  // Bytes are only consumed while receiving the header or data words.
  assign w_asm_en = (r_state == ST_HDR) || (r_state == ST_DATA);
  assign w_asm_rx = rx_ready && w_asm_en;

  byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (!w_asm_en),
    .i_rx_data    (rx_data),
    .i_rx_ready   (w_asm_rx),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Protocol sequencer with registered tx request, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_first    <= 1'b0;
      r_nack     <= 1'b0;
      r_k        <= '0;
      r_n        <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tx_data <= HELLO_BYTE;
            r_state   <= ST_HELLO_REQ;
          end
        end
        ST_HELLO_REQ: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_first    <= 1'b1;
            r_state    <= ST_HELLO_WAIT;
          end
        end
        ST_HELLO_WAIT: begin
          r_first <= 1'b0;
          if (!r_first && !tx_busy) r_state <= ST_HDR;
        end
        ST_HDR: begin
          if (w_word_valid) begin
            if (w_word > MAX_WORDS) begin
              r_nack    <= 1'b1;
              r_tx_data <= NACK_BYTE;
              r_state   <= ST_ACK_REQ;
            end else if (w_word == '0) begin
              r_nack    <= 1'b0;
              r_tx_data <= HELLO_BYTE;
              r_state   <= ST_ACK_REQ;
            end else begin
              r_n     <= w_word[INST_SIZE:0];
              r_k     <= '0;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // The write itself is the combinational strobe below; here only
          // the word index advances or the load completes.
          if (w_word_valid) begin
            if (r_k + 1'b1 == r_n) begin
              r_nack    <= 1'b0;
              r_tx_data <= HELLO_BYTE;
              r_state   <= ST_ACK_REQ;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        ST_ACK_REQ: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_first    <= 1'b1;
            r_state    <= ST_ACK_WAIT;
          end
        end
        ST_ACK_WAIT: begin
          r_first <= 1'b0;
          if (!r_first && !tx_busy) begin
            if (r_nack) begin
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_DONE;
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign imem_we    = w_word_valid && (r_state == ST_DATA);
  assign imem_addr  = r_k[INST_SIZE-1:0];
  assign imem_wdata = w_word;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule
